// File: rtl/instr_fetch_unit.sv
// Fetch stage: small loadable program memory sequenced by a PC,
// words handed to the decoder over a valid/ready handshake.
module instr_fetch_unit #(
   parameter int         ADDR_W  = 4,
   parameter int         INSTR_W = 18,
   parameter logic [3:0] HALT_OP = 4'b1000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_en,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               start,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id,
   output logic               id_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               halted
);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

   state_t             state, state_n;
   logic [INSTR_W-1:0] mem [2**ADDR_W];
   logic [INSTR_W-1:0] rd_q;
   logic [INSTR_W-1:0] id_n;
   logic [ADDR_W-1:0]  pc_n;
   logic               vld_n;
   logic               hlt_n;
   logic               ph;
   logic               ph_n;
   logic               wr_ok;

   assign wr_ok = (state == IDLE) || (state == HALT);
   assign busy  = (state == FETCH) || (state == ISSUE);

   always_ff @(posedge clk) begin
      if (load_en && wr_ok)
         mem[load_addr] <= load_data;
   end

   // pc is stable for both FETCH cycles, so rd_q is mem[pc] in phase 1
   always_ff @(posedge clk) begin
      rd_q <= mem[pc];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ph       <= 1'b0;
         id       <= '0;
         id_valid <= 1'b0;
         pc       <= '0;
         halted   <= 1'b0;
      end else begin
         state    <= state_n;
         ph       <= ph_n;
         id       <= id_n;
         id_valid <= vld_n;
         pc       <= pc_n;
         halted   <= hlt_n;
      end
   end

   always_comb begin
      state_n = state;
      ph_n    = ph;
      id_n    = id;
      vld_n   = id_valid;
      pc_n    = pc;
      hlt_n   = halted;
      unique case (state)
         IDLE: begin
            if (start) begin
               pc_n    = '0;
               ph_n    = 1'b0;
               state_n = FETCH;
            end
         end
         FETCH: begin
            if (!ph) begin
               ph_n = 1'b1;
            end else begin
               ph_n    = 1'b0;
               id_n    = rd_q;
               vld_n   = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (id_ready) begin
               vld_n = 1'b0;
               if (id[INSTR_W-1 -: 4] == HALT_OP) begin
                  hlt_n   = 1'b1;
                  state_n = HALT;
               end else begin
                  pc_n    = pc + ADDR_W'(1);
                  state_n = FETCH;
               end
            end
         end
         HALT: begin
            if (start) begin
               hlt_n   = 1'b0;
               pc_n    = '0;
               ph_n    = 1'b0;
               state_n = FETCH;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a transfer scoreboard.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_en;
   logic [3:0]  load_addr;
   logic [17:0] load_data;
   logic        start;
   logic        id_ready;
   logic [17:0] id;
   logic        id_valid;
   logic [3:0]  pc;
   logic        busy;
   logic        halted;

   int ncmp = 0;
   int nerr = 0;
   logic [21:0] sb[$];
   logic [17:0] prog [4];

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data),
      .start(start), .id_ready(id_ready), .id(id),
      .id_valid(id_valid), .pc(pc), .busy(busy),
      .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] a, input logic [17:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push_prog();
      for (int k = 0; k < 4; k++)
         sb.push_back({4'(k), prog[k]});
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 10 && !id_valid; i++)
         tick();
      check(tag, 32'(id_valid), 32'd1);
   endtask

   task automatic wait_halt(input string tag);
      for (int i = 0; i < 60 && !halted; i++)
         tick();
      check(tag, 32'(halted), 32'd1);
      check({tag, "_sb_drained"}, sb.size(), 0);
   endtask

   // every accepted transfer must match the next scoreboard entry
   always @(negedge clk) begin
      if (rst_n && id_valid && id_ready) begin
         check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            logic [21:0] e;
            e = sb.pop_front();
            check("xfer_pc", 32'(pc), 32'(e[21:18]));
            check("xfer_id", 32'(id), 32'(e[17:0]));
         end
      end
   end

   initial begin
      prog[0] = 18'b110010000011011000;
      prog[1] = 18'b101101110011101100;
      prog[2] = 18'b000110001111001100;
      prog[3] = 18'b100010111011001100;
      rst_n     = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      start     = 1'b0;
      id_ready  = 1'b0;
      tick();
      tick();
      check("rst_id", 32'(id), 32'd0);
      check("rst_valid", 32'(id_valid), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 4; k++)
         load(4'(k), prog[k]);

      // straight run with id_ready held high
      id_ready = 1'b1;
      push_prog();
      pulse_start();
      check("lat_busy", 32'(busy), 32'd1);
      check("lat_v0", 32'(id_valid), 32'd0);
      tick();
      check("lat_v1", 32'(id_valid), 32'd0);
      tick();
      check("lat_v2", 32'(id_valid), 32'd1);
      check("lat_id", 32'(id), 32'(prog[0]));
      check("lat_pc", 32'(pc), 32'd0);
      wait_halt("run1_halt");
      check("run1_busy", 32'(busy), 32'd0);
      check("run1_valid", 32'(id_valid), 32'd0);
      check("run1_id", 32'(id), 32'(prog[3]));

      // back-pressure on word 1
      id_ready = 1'b0;
      push_prog();
      pulse_start();
      check("bp_halted_clr", 32'(halted), 32'd0);
      wait_valid("bp_w0_valid");
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      wait_valid("bp_w1_valid");
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_id", 32'(id), 32'(prog[1]));
         check("bp_hold_valid", 32'(id_valid), 32'd1);
         check("bp_hold_pc", 32'(pc), 32'd1);
         tick();
      end
      id_ready = 1'b1;
      tick();
      check("bp_adv_valid", 32'(id_valid), 32'd0);
      check("bp_adv_pc", 32'(pc), 32'd2);
      wait_halt("bp_halt");

      // restart from HALT, with a write attempted while busy
      push_prog();
      pulse_start();
      check("rs_halted", 32'(halted), 32'd0);
      check("rs_busy", 32'(busy), 32'd1);
      tick();
      check("rs_v1", 32'(id_valid), 32'd0);
      tick();
      check("rs_v2", 32'(id_valid), 32'd1);
      check("rs_id", 32'(id), 32'(prog[0]));
      load(4'd2, 18'h3ffff);
      wait_halt("rs_halt");
      push_prog();
      pulse_start();
      wait_halt("nowr_halt");

      // asynchronous reset during ISSUE of word 1
      id_ready = 1'b0;
      sb.push_back({4'd0, prog[0]});
      pulse_start();
      wait_valid("ar_w0_valid");
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      wait_valid("ar_w1_valid");
      check("ar_w1_pc", 32'(pc), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(id_valid), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_pc", 32'(pc), 32'd0);
      check("ar_id", 32'(id), 32'd0);
      check("ar_sb", sb.size(), 0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      check("ar_idle_busy", 32'(busy), 32'd0);
      check("ar_idle_valid", 32'(id_valid), 32'd0);
      id_ready = 1'b1;
      push_prog();
      pulse_start();
      wait_halt("ar_mem_kept");

      // program without halt wraps pc 15 -> 0
      for (int k = 0; k < 16; k++)
         load(4'(k), {4'b0001, 14'(k)});
      for (int k = 0; k < 16; k++)
         sb.push_back({4'(k), 4'b0001, 14'(k)});
      sb.push_back({4'd0, 4'b0001, 14'd0});
      pulse_start();
      for (int i = 0; i < 120 && sb.size() > 0; i++)
         tick();
      check("wrap_sb_drained", sb.size(), 0);
      check("wrap_halted", 32'(halted), 32'd0);
      check("wrap_busy", 32'(busy), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
